// File: rtl/plab5_mcore_resp_acc_pkg.sv
// ---------------------------------------------------------------------------
// plab5_mcore_resp_acc_pkg
//
// Shared definitions for the requester-side security checker:
//   - mem message field geometry (opaque offset/width inside the request and
//     response control fields, i.e. the message with the data field removed)
//   - security level constants
//   - tag queue entry width
//
// Mem message layout (MSB..LSB):
//   request  : {type, opaque, addr, len, data}
//   response : {type, opaque, len, data}
// ---------------------------------------------------------------------------
package plab5_mcore_resp_acc_pkg;

    localparam int MEM_TYPE_NBITS = 3;

    localparam logic SEC_LOW  = 1'b0;
    localparam logic SEC_HIGH = 1'b1;

    // Width of the len field: log2 of the number of bytes in a data word.
    function automatic int len_nbits(input int data_nbits);
        return $clog2(data_nbits / 8);
    endfunction

    function automatic int req_cnbits(input int opaque_nbits, input int addr_nbits,
                                      input int data_nbits);
        return MEM_TYPE_NBITS + opaque_nbits + addr_nbits + len_nbits(data_nbits);
    endfunction

    function automatic int resp_cnbits(input int opaque_nbits, input int data_nbits);
        return MEM_TYPE_NBITS + opaque_nbits + len_nbits(data_nbits);
    endfunction

    // LSB position of the opaque field within the request control field.
    function automatic int req_opaque_lsb(input int addr_nbits, input int data_nbits);
        return addr_nbits + len_nbits(data_nbits);
    endfunction

    // LSB position of the opaque field within the response control field.
    function automatic int resp_opaque_lsb(input int data_nbits);
        return len_nbits(data_nbits);
    endfunction

    // Tag entry: {opaque, security level}.
    function automatic int tag_nbits(input int opaque_nbits);
        return opaque_nbits + 1;
    endfunction

endpackage

// File: rtl/plab5_mcore_sec_tag_queue.sv
// ---------------------------------------------------------------------------
// plab5_mcore_sec_tag_queue
//
// In-order circular FIFO holding one tag per outstanding request.
// The head entry is presented combinationally so the response classifier can
// compare against it in the same cycle the response arrives.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   enq_val, enq_data   push request (ignored while full)
//   deq_val             pop request (ignored while empty)
//   deq_data            current head entry
//   full, empty, count  occupancy status
// ---------------------------------------------------------------------------
module plab5_mcore_sec_tag_queue #(
    parameter  int p_width       = 9,
    parameter  int p_num_entries = 4,
    localparam int ptr_nbits     = $clog2(p_num_entries),
    localparam int cnt_nbits     = ptr_nbits + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enq_val,
    input  logic [p_width-1:0]   enq_data,
    input  logic                 deq_val,
    output logic [p_width-1:0]   deq_data,
    output logic                 full,
    output logic                 empty,
    output logic [cnt_nbits-1:0] count
);

    logic [p_width-1:0]   mem [p_num_entries];
    logic [ptr_nbits-1:0] wr_ptr_reg;
    logic [ptr_nbits-1:0] rd_ptr_reg;
    logic [cnt_nbits-1:0] count_reg;
    logic [cnt_nbits-1:0] count_next;

    logic enq_fire;
    logic deq_fire;

    assign full     = (count_reg == cnt_nbits'(p_num_entries));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign enq_fire = enq_val & ~full;
    assign deq_fire = deq_val & ~empty;
    assign deq_data = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (enq_fire && !deq_fire)
            count_next = count_reg + cnt_nbits'(1);
        else if (deq_fire && !enq_fire)
            count_next = count_reg - cnt_nbits'(1);
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (enq_fire)
                wr_ptr_reg <= wr_ptr_reg + ptr_nbits'(1);
            if (deq_fire)
                rd_ptr_reg <= rd_ptr_reg + ptr_nbits'(1);
            count_reg <= count_next;
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (enq_fire)
            mem[wr_ptr_reg] <= enq_data;
    end

endmodule

// File: rtl/plab5_mcore_resp_acc.sv
// ---------------------------------------------------------------------------
// plab5_mcore_resp_acc
//
// Requester-side security checker between a core/cache port and the memory
// network. Each forwarded request is stamped with the core's security level
// and its {opaque, level} tag is queued in order. Each returning response is
// checked against the head tag:
//   - no outstanding tag        : dropped, violation
//   - level matches head level  : delivered unmodified
//   - level differs or is X     : data zeroed, opaque forced to head opaque,
//                                 violation
// Responses pass through a one-entry output register (latency 1).
//
// Optional build macro:
//   PLAB5_RESP_ACC_STRICT_OPAQUE_EN - also treat an opaque mismatch against
//   the head tag as a violation (scrubbed), even when levels match.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   core_sec_level                 issuing core's level (0 low, 1 high)
//   core_req_* / net_req_*         request path (combinational)
//   net_req_sec_level              level stamped on the forwarded request
//   net_resp_* / core_resp_*       response path (registered)
//   net_resp_sec_level             level carried by the response (may be X)
//   violation                      one-cycle pulse per violating response
//   viol_count                     saturating violation counter
//   outstanding                    occupied tag entries
// ---------------------------------------------------------------------------
module plab5_mcore_resp_acc
    import plab5_mcore_resp_acc_pkg::*;
#(
    parameter  int p_opaque_nbits = 8,
    parameter  int p_addr_nbits   = 32,
    parameter  int p_data_nbits   = 32,
    parameter  int p_num_entries  = 4,
    localparam int req_cnbits     = plab5_mcore_resp_acc_pkg::req_cnbits(p_opaque_nbits, p_addr_nbits, p_data_nbits),
    localparam int resp_cnbits    = plab5_mcore_resp_acc_pkg::resp_cnbits(p_opaque_nbits, p_data_nbits),
    localparam int cnt_nbits      = $clog2(p_num_entries) + 1
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    core_sec_level,

    input  logic [req_cnbits-1:0]   core_req_control,
    input  logic [p_data_nbits-1:0] core_req_data,
    input  logic                    core_req_val,
    output logic                    core_req_rdy,

    output logic [req_cnbits-1:0]   net_req_control,
    output logic [p_data_nbits-1:0] net_req_data,
    output logic                    net_req_val,
    input  logic                    net_req_rdy,
    output logic                    net_req_sec_level,

    input  logic [resp_cnbits-1:0]  net_resp_control,
    input  logic [p_data_nbits-1:0] net_resp_data,
    input  logic                    net_resp_val,
    output logic                    net_resp_rdy,
    input  logic                    net_resp_sec_level,

    output logic [resp_cnbits-1:0]  core_resp_control,
    output logic [p_data_nbits-1:0] core_resp_data,
    output logic                    core_resp_val,
    input  logic                    core_resp_rdy,

    output logic                    violation,
    output logic [7:0]              viol_count,
    output logic [cnt_nbits-1:0]    outstanding
);

    localparam int TW  = tag_nbits(p_opaque_nbits);
    localparam int ROL = req_opaque_lsb(p_addr_nbits, p_data_nbits);
    localparam int RSL = resp_opaque_lsb(p_data_nbits);

    // ------------------------------------------------------------------
    // Tag queue
    // ------------------------------------------------------------------
    logic          q_full;
    logic          q_empty;
    logic [TW-1:0] q_head;
    logic [TW-1:0] q_enq_data;
    logic          push;
    logic          pop;

    logic [p_opaque_nbits-1:0] head_opaque;
    logic                      head_level;

    assign head_opaque = q_head[TW-1:1];
    assign head_level  = q_head[0];
    assign q_enq_data  = {core_req_control[ROL +: p_opaque_nbits], core_sec_level};

    plab5_mcore_sec_tag_queue #(
        .p_width       (TW),
        .p_num_entries (p_num_entries)
    ) tag_queue (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (push),
        .enq_data (q_enq_data),
        .deq_val  (pop),
        .deq_data (q_head),
        .full     (q_full),
        .empty    (q_empty),
        .count    (outstanding)
    );

    // ------------------------------------------------------------------
    // Request path: pass-through, blocked while the tag queue is full.
    // Full is the registered occupancy, so a same-cycle pop never frees a
    // slot for a same-cycle push.
    // ------------------------------------------------------------------
    assign net_req_val       = core_req_val & ~q_full;
    assign net_req_control   = q_full ? '0 : core_req_control;
    assign net_req_data      = q_full ? '0 : core_req_data;
    assign net_req_sec_level = core_sec_level;
    assign core_req_rdy      = net_req_rdy & ~q_full;
    assign push              = net_req_val & net_req_rdy;

    // ------------------------------------------------------------------
    // Response classification
    // ------------------------------------------------------------------
    logic                      core_resp_val_reg,  core_resp_val_next;
    logic [resp_cnbits-1:0]    core_resp_ctrl_reg, core_resp_ctrl_next;
    logic [p_data_nbits-1:0]   core_resp_data_reg, core_resp_data_next;
    logic                      violation_reg,      violation_next;
    logic [7:0]                viol_count_reg,     viol_count_next;

    logic                      resp_fire;
    logic                      level_ok;
    logic                      tag_ok;
    logic [resp_cnbits-1:0]    scrub_ctrl;

    assign net_resp_rdy = ~core_resp_val_reg | core_resp_rdy;
    assign resp_fire    = net_resp_val & net_resp_rdy;
    assign pop          = resp_fire & ~q_empty;

    // Case equality so an X level on the response never counts as a match.
    assign level_ok = (net_resp_sec_level === head_level);

`ifdef PLAB5_RESP_ACC_STRICT_OPAQUE_EN
    assign tag_ok = level_ok && (net_resp_control[RSL +: p_opaque_nbits] == head_opaque);
`else
    assign tag_ok = level_ok;
`endif

    // Scrubbed responses carry the head opaque so the core can still retire
    // the request it was actually waiting on.
    always_comb begin
        scrub_ctrl = net_resp_control;
        scrub_ctrl[RSL +: p_opaque_nbits] = head_opaque;
    end

    always_comb begin
        core_resp_val_next  = core_resp_val_reg & ~core_resp_rdy;
        core_resp_ctrl_next = core_resp_ctrl_reg;
        core_resp_data_next = core_resp_data_reg;
        violation_next      = 1'b0;

        if (resp_fire) begin
            if (q_empty) begin
                violation_next = 1'b1;
            end else if (tag_ok) begin
                core_resp_val_next  = 1'b1;
                core_resp_ctrl_next = net_resp_control;
                core_resp_data_next = net_resp_data;
            end else begin
                core_resp_val_next  = 1'b1;
                core_resp_ctrl_next = scrub_ctrl;
                core_resp_data_next = '0;
                violation_next      = 1'b1;
            end
        end

        viol_count_next = viol_count_reg;
        if (violation_next && (viol_count_reg != 8'hFF))
            viol_count_next = viol_count_reg + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_resp_val_reg  <= 1'b0;
            core_resp_ctrl_reg <= '0;
            core_resp_data_reg <= '0;
            violation_reg      <= 1'b0;
            viol_count_reg     <= 8'd0;
        end else begin
            core_resp_val_reg  <= core_resp_val_next;
            core_resp_ctrl_reg <= core_resp_ctrl_next;
            core_resp_data_reg <= core_resp_data_next;
            violation_reg      <= violation_next;
            viol_count_reg     <= viol_count_next;
        end
    end

    assign core_resp_val     = core_resp_val_reg;
    assign core_resp_control = core_resp_ctrl_reg;
    assign core_resp_data    = core_resp_data_reg;
    assign violation         = violation_reg;
    assign viol_count        = viol_count_reg;

endmodule

// File: tb/tb_plab5_mcore_resp_acc.sv
// ---------------------------------------------------------------------------
// tb_plab5_mcore_resp_acc
//
// Directed testbench for plab5_mcore_resp_acc with default parameters
// (opaque 8, addr 32, data 32, 4 entries): request control is 45 bits
// {type[3], opaque[8], addr[32], len[2]}, response control is 13 bits
// {type[3], opaque[8], len[2]}.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// before the next rising edge.
// ---------------------------------------------------------------------------
module tb_plab5_mcore_resp_acc;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_sec_level;
    logic [44:0] core_req_control;
    logic [31:0] core_req_data;
    logic        core_req_val;
    logic        core_req_rdy;
    logic [44:0] net_req_control;
    logic [31:0] net_req_data;
    logic        net_req_val;
    logic        net_req_rdy;
    logic        net_req_sec_level;
    logic [12:0] net_resp_control;
    logic [31:0] net_resp_data;
    logic        net_resp_val;
    logic        net_resp_rdy;
    logic        net_resp_sec_level;
    logic [12:0] core_resp_control;
    logic [31:0] core_resp_data;
    logic        core_resp_val;
    logic        core_resp_rdy;
    logic        violation;
    logic [7:0]  viol_count;
    logic [2:0]  outstanding;

    int total = 0;
    int bad   = 0;
    int exp_vc = 0;

    always #5 clk = ~clk;

    plab5_mcore_resp_acc dut (
        .clk                (clk),
        .reset              (reset),
        .core_sec_level     (core_sec_level),
        .core_req_control   (core_req_control),
        .core_req_data      (core_req_data),
        .core_req_val       (core_req_val),
        .core_req_rdy       (core_req_rdy),
        .net_req_control    (net_req_control),
        .net_req_data       (net_req_data),
        .net_req_val        (net_req_val),
        .net_req_rdy        (net_req_rdy),
        .net_req_sec_level  (net_req_sec_level),
        .net_resp_control   (net_resp_control),
        .net_resp_data      (net_resp_data),
        .net_resp_val       (net_resp_val),
        .net_resp_rdy       (net_resp_rdy),
        .net_resp_sec_level (net_resp_sec_level),
        .core_resp_control  (core_resp_control),
        .core_resp_data     (core_resp_data),
        .core_resp_val      (core_resp_val),
        .core_resp_rdy      (core_resp_rdy),
        .violation          (violation),
        .viol_count         (viol_count),
        .outstanding        (outstanding)
    );

    function automatic logic [44:0] mk_req(input logic [7:0] opq);
        return {3'd0, opq, 32'h0000_1000 + {24'd0, opq}, 2'd0};
    endfunction

    function automatic logic [12:0] mk_resp(input logic [7:0] opq);
        return {3'd0, opq, 2'd0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        core_sec_level     = 1'b0;
        core_req_control   = '0;
        core_req_data      = '0;
        core_req_val       = 1'b0;
        net_req_rdy        = 1'b1;
        net_resp_control   = '0;
        net_resp_data      = '0;
        net_resp_val       = 1'b0;
        net_resp_sec_level = 1'b0;
        core_resp_rdy      = 1'b1;
    endtask

    task automatic drive_req(input logic [7:0] opq, input logic lvl);
        core_req_val     = 1'b1;
        core_req_control = mk_req(opq);
        core_req_data    = 32'h0;
        core_sec_level   = lvl;
    endtask

    task automatic drive_resp(input logic [7:0] opq, input logic lvl, input logic [31:0] d);
        net_resp_val       = 1'b1;
        net_resp_control   = mk_resp(opq);
        net_resp_sec_level = lvl;
        net_resp_data      = d;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        clear_inputs();
        #1 reset = 1'b1;
        tick();
        tick();
        total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
        total++; if (core_resp_val !== 1'b0) begin bad++; $display("FAIL reset_resp_val got=%b exp=0", core_resp_val); end
        total++; if (core_resp_data !== 32'h0) begin bad++; $display("FAIL reset_resp_data got=%h exp=0", core_resp_data); end
        total++; if (core_resp_control !== 13'h0) begin bad++; $display("FAIL reset_resp_ctrl got=%h exp=0", core_resp_control); end
        total++; if (violation !== 1'b0) begin bad++; $display("FAIL reset_violation got=%b exp=0", violation); end
        total++; if (viol_count !== 8'd0) begin bad++; $display("FAIL reset_viol_count got=%0d exp=0", viol_count); end
        reset = 1'b0;
        tick();
        $display("txn reset done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_low_read;
        drive_req(8'h05, 1'b0);
        #1;
        total++; if (core_req_rdy !== 1'b1) begin bad++; $display("FAIL low_req_rdy got=%b exp=1", core_req_rdy); end
        total++; if (net_req_val !== 1'b1) begin bad++; $display("FAIL low_net_req_val got=%b exp=1", net_req_val); end
        total++; if (net_req_sec_level !== 1'b0) begin bad++; $display("FAIL low_net_level got=%b exp=0", net_req_sec_level); end
        total++; if (net_req_control !== mk_req(8'h05)) begin bad++; $display("FAIL low_net_ctrl got=%h exp=%h", net_req_control, mk_req(8'h05)); end
        tick();
        core_req_val = 1'b0;
        #1;
        total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL low_outstanding1 got=%0d exp=1", outstanding); end
        drive_resp(8'h05, 1'b0, 32'hDEADBEEF);
        #1;
        total++; if (net_resp_rdy !== 1'b1) begin bad++; $display("FAIL low_resp_rdy got=%b exp=1", net_resp_rdy); end
        total++; if (core_resp_val !== 1'b0) begin bad++; $display("FAIL low_resp_early got=%b exp=0", core_resp_val); end
        tick();
        net_resp_val = 1'b0;
        #1;
        total++; if (core_resp_val !== 1'b1) begin bad++; $display("FAIL low_resp_val got=%b exp=1", core_resp_val); end
        total++; if (core_resp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL low_resp_data got=%h exp=deadbeef", core_resp_data); end
        total++; if (core_resp_control !== mk_resp(8'h05)) begin bad++; $display("FAIL low_resp_ctrl got=%h exp=%h", core_resp_control, mk_resp(8'h05)); end
        total++; if (violation !== 1'b0) begin bad++; $display("FAIL low_violation got=%b exp=0", violation); end
        total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL low_outstanding0 got=%0d exp=0", outstanding); end
        tick();
        total++; if (core_resp_val !== 1'b0) begin bad++; $display("FAIL low_resp_drop got=%b exp=0", core_resp_val); end
        $display("txn low read opaque=05 data=%h", core_resp_data);
    endtask

    // ------------------------------------------------------------------
    task automatic test_dummy;
        drive_req(8'h07, 1'b1);
        #1;
        total++; if (net_req_sec_level !== 1'b1) begin bad++; $display("FAIL dummy_net_level got=%b exp=1", net_req_sec_level); end
        tick();
        core_req_val = 1'b0;
        // Wrong opaque on the response as well: delivered opaque must be the head's.
        drive_resp(8'h33, 1'b0, 32'hxxxxxxxx);
        tick();
        net_resp_val = 1'b0;
        exp_vc++;
        #1;
        total++; if (core_resp_val !== 1'b1) begin bad++; $display("FAIL dummy_resp_val got=%b exp=1", core_resp_val); end
        total++; if (core_resp_data !== 32'h0) begin bad++; $display("FAIL dummy_resp_data got=%h exp=0", core_resp_data); end
        total++; if (core_resp_control !== mk_resp(8'h07)) begin bad++; $display("FAIL dummy_resp_ctrl got=%h exp=%h", core_resp_control, mk_resp(8'h07)); end
        total++; if (violation !== 1'b1) begin bad++; $display("FAIL dummy_violation got=%b exp=1", violation); end
        total++; if (viol_count !== 8'(exp_vc)) begin bad++; $display("FAIL dummy_viol_count got=%0d exp=%0d", viol_count, exp_vc); end
        tick();
        total++; if (violation !== 1'b0) begin bad++; $display("FAIL dummy_violation_pulse got=%b exp=0", violation); end
        $display("txn dummy high opaque=07 viol_count=%0d", viol_count);
    endtask

    // ------------------------------------------------------------------
    task automatic test_full;
        for (int i = 1; i <= 4; i++) begin
            drive_req(8'(i), 1'b0);
            #1;
            total++; if (core_req_rdy !== 1'b1) begin bad++; $display("FAIL full_fill_rdy%0d got=%b exp=1", i, core_req_rdy); end
            tick();
        end
        // Fifth request is from a high core; it must keep level 1 once queued.
        drive_req(8'h05, 1'b1);
        #1;
        total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL full_outstanding4 got=%0d exp=4", outstanding); end
        total++; if (core_req_rdy !== 1'b0) begin bad++; $display("FAIL full_req_rdy got=%b exp=0", core_req_rdy); end
        total++; if (net_req_val !== 1'b0) begin bad++; $display("FAIL full_net_req_val got=%b exp=0", net_req_val); end
        drive_resp(8'h01, 1'b0, 32'h0000_0011);
        #1;
        total++; if (core_req_rdy !== 1'b0) begin bad++; $display("FAIL full_same_cycle_rdy got=%b exp=0", core_req_rdy); end
        tick();
        net_resp_val = 1'b0;
        #1;
        total++; if (outstanding !== 3'd3) begin bad++; $display("FAIL full_outstanding3 got=%0d exp=3", outstanding); end
        total++; if (core_req_rdy !== 1'b1) begin bad++; $display("FAIL full_next_rdy got=%b exp=1", core_req_rdy); end
        total++; if (core_resp_data !== 32'h0000_0011) begin bad++; $display("FAIL full_resp_data got=%h exp=00000011", core_resp_data); end
        tick();
        core_req_val   = 1'b0;
        core_sec_level = 1'b0;
        #1;
        total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL full_refill got=%0d exp=4", outstanding); end
        $display("txn full queue: 5th request accepted one cycle after pop");
    endtask

    // ------------------------------------------------------------------
    // Drain tags 2,3,4 (low) and 5 (high) with low responses, one per cycle.
    task automatic test_back_to_back;
        logic [31:0] d;
        logic        exp_v;
        for (int i = 0; i < 4; i++) begin
            d = 32'h0000_0020 + 32'(i);
            drive_resp(8'(i + 2), 1'b0, d);
            tick();
            exp_v = (i == 3);
            if (exp_v) exp_vc++;
            #1;
            total++; if (core_resp_val !== 1'b1) begin bad++; $display("FAIL b2b_val%0d got=%b exp=1", i, core_resp_val); end
            total++; if (core_resp_data !== (exp_v ? 32'h0 : d)) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", i, core_resp_data, exp_v ? 32'h0 : d); end
            total++; if (core_resp_control !== mk_resp(8'(i + 2))) begin bad++; $display("FAIL b2b_ctrl%0d got=%h exp=%h", i, core_resp_control, mk_resp(8'(i + 2))); end
            total++; if (violation !== exp_v) begin bad++; $display("FAIL b2b_viol%0d got=%b exp=%b", i, violation, exp_v); end
            total++; if (outstanding !== 3'(3 - i)) begin bad++; $display("FAIL b2b_outstanding%0d got=%0d exp=%0d", i, outstanding, 3 - i); end
            $display("txn b2b resp opaque=%0h data=%h viol=%b", i + 2, core_resp_data, violation);
        end
        net_resp_val = 1'b0;
        total++; if (viol_count !== 8'(exp_vc)) begin bad++; $display("FAIL b2b_viol_count got=%0d exp=%0d", viol_count, exp_vc); end
        tick();
        total++; if (core_resp_val !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", core_resp_val); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_unexpected;
        drive_resp(8'h44, 1'b0, 32'h5555_AAAA);
        #1;
        total++; if (net_resp_rdy !== 1'b1) begin bad++; $display("FAIL unexp_rdy got=%b exp=1", net_resp_rdy); end
        tick();
        net_resp_val = 1'b0;
        exp_vc++;
        #1;
        total++; if (core_resp_val !== 1'b0) begin bad++; $display("FAIL unexp_resp_val got=%b exp=0", core_resp_val); end
        total++; if (violation !== 1'b1) begin bad++; $display("FAIL unexp_violation got=%b exp=1", violation); end
        total++; if (viol_count !== 8'(exp_vc)) begin bad++; $display("FAIL unexp_viol_count got=%0d exp=%0d", viol_count, exp_vc); end
        total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL unexp_outstanding got=%0d exp=0", outstanding); end
        tick();
        total++; if (violation !== 1'b0) begin bad++; $display("FAIL unexp_pulse got=%b exp=0", violation); end
        $display("txn unexpected response dropped viol_count=%0d", viol_count);
    endtask

    // ------------------------------------------------------------------
    task automatic test_strict;
        logic [31:0] exp_d;
        logic [12:0] exp_c;
        logic        exp_v;
        drive_req(8'h08, 1'b0);
        tick();
        core_req_val = 1'b0;
        drive_resp(8'h09, 1'b0, 32'h1234_5678);
        tick();
        net_resp_val = 1'b0;
`ifdef PLAB5_RESP_ACC_STRICT_OPAQUE_EN
        exp_d = 32'h0;
        exp_c = mk_resp(8'h08);
        exp_v = 1'b1;
`else
        exp_d = 32'h1234_5678;
        exp_c = mk_resp(8'h09);
        exp_v = 1'b0;
`endif
        if (exp_v) exp_vc++;
        #1;
        total++; if (core_resp_val !== 1'b1) begin bad++; $display("FAIL strict_val got=%b exp=1", core_resp_val); end
        total++; if (core_resp_data !== exp_d) begin bad++; $display("FAIL strict_data got=%h exp=%h", core_resp_data, exp_d); end
        total++; if (core_resp_control !== exp_c) begin bad++; $display("FAIL strict_ctrl got=%h exp=%h", core_resp_control, exp_c); end
        total++; if (violation !== exp_v) begin bad++; $display("FAIL strict_viol got=%b exp=%b", violation, exp_v); end
        total++; if (viol_count !== 8'(exp_vc)) begin bad++; $display("FAIL strict_viol_count got=%0d exp=%0d", viol_count, exp_vc); end
        total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL strict_outstanding got=%0d exp=0", outstanding); end
        tick();
        $display("txn opaque mismatch 09 vs 08 data=%h viol=%b", exp_d, exp_v);
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall_reset;
        drive_req(8'h0A, 1'b0);
        tick();
        drive_req(8'h0B, 1'b0);
        tick();
        core_req_val  = 1'b0;
        core_resp_rdy = 1'b0;
        drive_resp(8'h0A, 1'b0, 32'h0000_000A);
        tick();
        drive_resp(8'h0B, 1'b0, 32'h0000_000B);
        #1;
        total++; if (net_resp_rdy !== 1'b0) begin bad++; $display("FAIL stall_rdy got=%b exp=0", net_resp_rdy); end
        total++; if (core_resp_val !== 1'b1) begin bad++; $display("FAIL stall_val got=%b exp=1", core_resp_val); end
        tick();
        total++; if (core_resp_data !== 32'h0000_000A) begin bad++; $display("FAIL stall_hold_data got=%h exp=0000000a", core_resp_data); end
        total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL stall_outstanding got=%0d exp=1", outstanding); end
        // Asynchronous reset in the middle of the cycle.
        reset = 1'b1;
        #1;
        total++; if (core_resp_val !== 1'b0) begin bad++; $display("FAIL arst_val got=%b exp=0", core_resp_val); end
        total++; if (core_resp_data !== 32'h0) begin bad++; $display("FAIL arst_data got=%h exp=0", core_resp_data); end
        total++; if (core_resp_control !== 13'h0) begin bad++; $display("FAIL arst_ctrl got=%h exp=0", core_resp_control); end
        total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL arst_outstanding got=%0d exp=0", outstanding); end
        total++; if (viol_count !== 8'd0) begin bad++; $display("FAIL arst_viol_count got=%0d exp=0", viol_count); end
        total++; if (net_resp_rdy !== 1'b1) begin bad++; $display("FAIL arst_resp_rdy got=%b exp=1", net_resp_rdy); end
        clear_inputs();
        tick();
        reset = 1'b0;
        tick();
        $display("txn stall then async reset");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_low_read();
        test_dummy();
        test_full();
        test_back_to_back();
        test_unexpected();
        test_strict();
        test_stall_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
